// File: rtl/mem_port_arbiter.sv
// Two-master memory bus arbiter: instruction fetch (read-only) and data access (read/write).
// Define ARB_RR_EN for round-robin tie breaking; otherwise the data port has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_read,
    output logic                    if_req_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_rdata_valid,
    input  logic                    if_rdata_ready,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic                    dm_read,
    input  logic                    dm_write,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_strb,
    output logic                    dm_req_ready,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_rdata_valid,
    input  logic                    dm_rdata_ready,
    output logic [ADDR_WIDTH-1:0]   Mem_Addr,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic [DATA_WIDTH-1:0]   Write_data,
    output logic [DATA_WIDTH/8-1:0] Write_strb,
    input  logic                    Mem_Req_Ready,
    input  logic [DATA_WIDTH-1:0]   Read_data,
    input  logic                    Read_data_Valid,
    output logic                    Read_data_Ready,
    output logic [1:0]              arb_owner
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        I_REQ = 5'b00010,
        D_REQ = 5'b00100,
        I_RSP = 5'b01000,
        D_RSP = 5'b10000
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] owner_r;
    logic       flush_r;
    logic       if_pend_s;
    logic       dm_pend_s;
    logic       pick_data_s;
    logic       rsp_ready_s;

    function automatic logic [1:0] owner_of(input state_t s);
        logic [1:0] o;
        case (s)
            I_REQ, I_RSP: o = 2'b01;
            D_REQ, D_RSP: o = 2'b10;
            default:      o = 2'b00;
        endcase
        return o;
    endfunction

    assign if_pend_s = if_read;
    assign dm_pend_s = dm_read | dm_write;
    assign arb_owner = owner_r;

`ifdef ARB_RR_EN
    logic last_data_r;

    // Remember which master received the most recent grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_r <= 1'b0;
        end else if ((state_r == IDLE) && (state_s == D_REQ)) begin
            last_data_r <= 1'b1;
        end else if ((state_r == IDLE) && (state_s == I_REQ)) begin
            last_data_r <= 1'b0;
        end else begin
            last_data_r <= last_data_r;
        end
    end

    assign pick_data_s = ~last_data_r;
`else
    // Data is the older instruction in the pipeline, so it always wins a tie
    assign pick_data_s = 1'b1;
`endif

    // State and owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= 2'b00;
        end else begin
            state_r <= state_s;
            owner_r <= owner_of(state_s);
        end
    end

    // Flush flag drains any bus response left over from before reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r <= 1'b1;
        end else begin
            flush_r <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (dm_pend_s && if_pend_s) begin
                    state_s = pick_data_s ? D_REQ : I_REQ;
                end else if (dm_pend_s) begin
                    state_s = D_REQ;
                end else if (if_pend_s) begin
                    state_s = I_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            I_REQ: begin
                if (!if_pend_s) begin
                    state_s = IDLE;
                end else if (Mem_Req_Ready) begin
                    state_s = I_RSP;
                end else begin
                    state_s = I_REQ;
                end
            end
            D_REQ: begin
                if (!dm_pend_s) begin
                    state_s = IDLE;
                end else if (Mem_Req_Ready) begin
                    state_s = dm_read ? D_RSP : IDLE;
                end else begin
                    state_s = D_REQ;
                end
            end
            I_RSP: begin
                if (Read_data_Valid && if_rdata_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = I_RSP;
                end
            end
            D_RSP: begin
                if (Read_data_Valid && dm_rdata_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = D_RSP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Route bus and handshake signals to and from the current owner
    always_comb begin
        Mem_Addr       = {ADDR_WIDTH{1'b0}};
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        Write_data     = {DATA_WIDTH{1'b0}};
        Write_strb     = {(DATA_WIDTH/8){1'b0}};
        if_req_ready   = 1'b0;
        dm_req_ready   = 1'b0;
        if_rdata       = {DATA_WIDTH{1'b0}};
        dm_rdata       = {DATA_WIDTH{1'b0}};
        if_rdata_valid = 1'b0;
        dm_rdata_valid = 1'b0;
        rsp_ready_s    = 1'b0;
        case (state_r)
            I_REQ: begin
                Mem_Addr     = if_addr;
                MemRead      = if_read;
                if_req_ready = Mem_Req_Ready;
            end
            D_REQ: begin
                Mem_Addr     = dm_addr;
                MemRead      = dm_read;
                MemWrite     = dm_write;
                Write_data   = dm_wdata;
                Write_strb   = dm_strb;
                dm_req_ready = Mem_Req_Ready;
            end
            I_RSP: begin
                if_rdata       = Read_data;
                if_rdata_valid = Read_data_Valid;
                rsp_ready_s    = if_rdata_ready;
            end
            D_RSP: begin
                dm_rdata       = Read_data;
                dm_rdata_valid = Read_data_Valid;
                rsp_ready_s    = dm_rdata_ready;
            end
            default: begin
                rsp_ready_s = 1'b0;
            end
        endcase
        Read_data_Ready = flush_r | rsp_ready_s;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; honours ARB_RR_EN for tie expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_addr;
    logic        if_read;
    logic        if_req_ready;
    logic [31:0] if_rdata;
    logic        if_rdata_valid;
    logic        if_rdata_ready;
    logic [31:0] dm_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_strb;
    logic        dm_req_ready;
    logic [31:0] dm_rdata;
    logic        dm_rdata_valid;
    logic        dm_rdata_ready;
    logic [31:0] Mem_Addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic [1:0]  arb_owner;

    int checks = 0;
    int errors = 0;
    int mr_cnt = 0;
    int mw_cnt = 0;
    int dmrr_cnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    req_t        req_q[$];
    logic [31:0] if_rsp_q[$];
    logic [31:0] dm_rsp_q[$];

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_read(if_read), .if_req_ready(if_req_ready),
        .if_rdata(if_rdata), .if_rdata_valid(if_rdata_valid), .if_rdata_ready(if_rdata_ready),
        .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write), .dm_wdata(dm_wdata),
        .dm_strb(dm_strb), .dm_req_ready(dm_req_ready), .dm_rdata(dm_rdata),
        .dm_rdata_valid(dm_rdata_valid), .dm_rdata_ready(dm_rdata_ready),
        .Mem_Addr(Mem_Addr), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ready(Read_data_Ready), .arb_owner(arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
        req_t e;
        e.addr  = a;
        e.we    = we;
        e.wdata = d;
        e.strb  = s;
        req_q.push_back(e);
    endtask

    // Scoreboard: compare every bus request and response handshake against the queues
    task automatic observe();
        req_t        e;
        logic [31:0] d;
        if ((MemRead || MemWrite) && Mem_Req_Ready) begin
            check("req_expected", 64'(req_q.size() != 0), 64'd1);
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                check("req_addr", 64'(Mem_Addr), 64'(e.addr));
                check("req_write", 64'(MemWrite), 64'(e.we));
                check("req_read", 64'(MemRead), 64'(!e.we));
                if (e.we) begin
                    check("req_wdata", 64'(Write_data), 64'(e.wdata));
                    check("req_strb", 64'(Write_strb), 64'(e.strb));
                end
            end
        end
        if (if_rdata_valid && if_rdata_ready) begin
            check("if_rsp_expected", 64'(if_rsp_q.size() != 0), 64'd1);
            if (if_rsp_q.size() != 0) begin
                d = if_rsp_q.pop_front();
                check("if_rdata", 64'(if_rdata), 64'(d));
            end
        end
        if (dm_rdata_valid && dm_rdata_ready) begin
            check("dm_rsp_expected", 64'(dm_rsp_q.size() != 0), 64'd1);
            if (dm_rsp_q.size() != 0) begin
                d = dm_rsp_q.pop_front();
                check("dm_rdata", 64'(dm_rdata), 64'(d));
            end
        end
        if (MemRead) mr_cnt++;
        if (MemWrite) mw_cnt++;
        if (dm_req_ready) dmrr_cnt++;
    endtask

    task automatic fetch_read(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if_addr = a; if_read = 1'b1; if_rdata_ready = 1'b1; Mem_Req_Ready = 1'b1;
        push_req(a, 1'b0, 32'h0, 4'h0);
        mr_cnt = 0;
        #1; observe();
        check("rd_bubble_memread", 64'(MemRead), 64'd0);
        check("rd_bubble_owner", 64'(arb_owner), 64'd0);
        @(negedge clk); #1; observe();
        check("rd_req_owner", 64'(arb_owner), 64'd1);
        check("rd_req_ready", 64'(if_req_ready), 64'd1);
        @(negedge clk);
        if_read = 1'b0; Read_data = d; Read_data_Valid = 1'b1;
        if_rsp_q.push_back(d);
        #1; observe();
        check("rd_rsp_owner", 64'(arb_owner), 64'd1);
        check("rd_rsp_valid", 64'(if_rdata_valid), 64'd1);
        check("rd_rsp_data", 64'(if_rdata), 64'(d));
        check("rd_rsp_rdr", 64'(Read_data_Ready), 64'd1);
        check("rd_rsp_dm_valid", 64'(dm_rdata_valid), 64'd0);
        @(negedge clk);
        Read_data_Valid = 1'b0; Mem_Req_Ready = 1'b0;
        #1; observe();
        check("rd_idle_owner", 64'(arb_owner), 64'd0);
        check("rd_memread_cycles", 64'(mr_cnt), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        if_addr = 32'h0; if_read = 1'b0; if_rdata_ready = 1'b1;
        dm_addr = 32'h0; dm_read = 1'b0; dm_write = 1'b0; dm_wdata = 32'h0; dm_strb = 4'h0;
        dm_rdata_ready = 1'b1; Mem_Req_Ready = 1'b0;
        Read_data = 32'h0BAD_0BAD; Read_data_Valid = 1'b1;

        // Reset with a stale response on the bus
        @(negedge clk); #1; observe();
        check("rst_owner", 64'(arb_owner), 64'd0);
        check("rst_rdr", 64'(Read_data_Ready), 64'd1);
        check("rst_memread", 64'(MemRead), 64'd0);
        check("rst_memwrite", 64'(MemWrite), 64'd0);
        check("rst_if_req_ready", 64'(if_req_ready), 64'd0);
        check("rst_dm_req_ready", 64'(dm_req_ready), 64'd0);
        check("rst_if_valid", 64'(if_rdata_valid), 64'd0);
        check("rst_dm_valid", 64'(dm_rdata_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1; observe();
        check("flush_rdr_high", 64'(Read_data_Ready), 64'd1);
        check("flush_owner", 64'(arb_owner), 64'd0);
        @(negedge clk); #1; observe();
        check("flush_rdr_low", 64'(Read_data_Ready), 64'd0);
        check("flush_if_valid", 64'(if_rdata_valid), 64'd0);
        check("flush_dm_valid", 64'(dm_rdata_valid), 64'd0);
        check("flush_owner_idle", 64'(arb_owner), 64'd0);
        Read_data_Valid = 1'b0;

        // Data write with three wait cycles
        @(negedge clk);
        dm_addr = 32'h0000_2004; dm_write = 1'b1; dm_wdata = 32'h1234_5678; dm_strb = 4'b0011;
        Mem_Req_Ready = 1'b0;
        push_req(32'h0000_2004, 1'b1, 32'h1234_5678, 4'b0011);
        mw_cnt = 0; dmrr_cnt = 0;
        #1; observe();
        check("wr_bubble", 64'(MemWrite), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            Mem_Req_Ready = (k == 3);
            #1; observe();
            check("wr_memwrite", 64'(MemWrite), 64'd1);
            check("wr_memread", 64'(MemRead), 64'd0);
            check("wr_addr", 64'(Mem_Addr), 64'h2004);
            check("wr_wdata", 64'(Write_data), 64'h1234_5678);
            check("wr_strb", 64'(Write_strb), 64'h3);
            check("wr_owner", 64'(arb_owner), 64'd2);
            check("wr_req_ready", 64'(dm_req_ready), 64'(k == 3));
        end
        @(negedge clk);
        dm_write = 1'b0; Mem_Req_Ready = 1'b0;
        #1; observe();
        check("wr_done_owner", 64'(arb_owner), 64'd0);
        check("wr_done_memwrite", 64'(MemWrite), 64'd0);
        check("wr_memwrite_cycles", 64'(mw_cnt), 64'd4);
        check("wr_req_ready_pulses", 64'(dmrr_cnt), 64'd1);

        fetch_read(32'h0000_1000, 32'hDEAD_BEEF);

        // Simultaneous requests, four rounds
        for (int r = 0; r < 4; r++) begin
            logic win_data;
            win_data = 1'b1;
`ifdef ARB_RR_EN
            win_data = ((r % 2) == 0);
`endif
            @(negedge clk);
            if_addr = 32'h3000 + 32'(r * 4); dm_addr = 32'h4000 + 32'(r * 4);
            if_read = 1'b1; dm_read = 1'b1; Mem_Req_Ready = 1'b1;
            if (win_data) push_req(dm_addr, 1'b0, 32'h0, 4'h0);
            else push_req(if_addr, 1'b0, 32'h0, 4'h0);
            #1; observe();
            check("tie_bubble_owner", 64'(arb_owner), 64'd0);
            @(negedge clk); #1; observe();
            check("tie_owner", 64'(arb_owner), win_data ? 64'd2 : 64'd1);
            check("tie_loser_req_ready", 64'(win_data ? if_req_ready : dm_req_ready), 64'd0);
            @(negedge clk);
            if_read = 1'b0; dm_read = 1'b0;
            Read_data = 32'hA000_0000 + 32'(r); Read_data_Valid = 1'b1;
            if (win_data) dm_rsp_q.push_back(32'hA000_0000 + 32'(r));
            else if_rsp_q.push_back(32'hA000_0000 + 32'(r));
            #1; observe();
            check("tie_winner_valid", 64'(win_data ? dm_rdata_valid : if_rdata_valid), 64'd1);
            check("tie_loser_valid", 64'(win_data ? if_rdata_valid : dm_rdata_valid), 64'd0);
            @(negedge clk);
            Read_data_Valid = 1'b0;
            #1; observe();
            check("tie_idle_owner", 64'(arb_owner), 64'd0);
        end

        // Fetch arrives while data response is stalled
        @(negedge clk);
        dm_addr = 32'h0000_5000; dm_read = 1'b1; dm_rdata_ready = 1'b0; Mem_Req_Ready = 1'b1;
        push_req(32'h0000_5000, 1'b0, 32'h0, 4'h0);
        #1; observe();
        @(negedge clk); #1; observe();
        check("dr_req_owner", 64'(arb_owner), 64'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            dm_read = 1'b0; if_addr = 32'h0000_6000; if_read = 1'b1;
            if (k == 0) push_req(32'h0000_6000, 1'b0, 32'h0, 4'h0);
            Read_data = 32'hCAFE_F00D; Read_data_Valid = 1'b1;
            #1; observe();
            check("dr_stall_owner", 64'(arb_owner), 64'd2);
            check("dr_stall_valid", 64'(dm_rdata_valid), 64'd1);
            check("dr_stall_rdr", 64'(Read_data_Ready), 64'd0);
            check("dr_stall_memread", 64'(MemRead), 64'd0);
            check("dr_stall_if_req_ready", 64'(if_req_ready), 64'd0);
        end
        @(negedge clk);
        dm_rdata_ready = 1'b1; dm_rsp_q.push_back(32'hCAFE_F00D);
        #1; observe();
        check("dr_rsp_rdr", 64'(Read_data_Ready), 64'd1);
        @(negedge clk);
        Read_data_Valid = 1'b0;
        #1; observe();
        check("dr_bubble_owner", 64'(arb_owner), 64'd0);
        check("dr_bubble_memread", 64'(MemRead), 64'd0);
        @(negedge clk); #1; observe();
        check("dr_fetch_owner", 64'(arb_owner), 64'd1);
        check("dr_fetch_memread", 64'(MemRead), 64'd1);
        @(negedge clk);
        if_read = 1'b0; Read_data = 32'h0BAD_CAFE; Read_data_Valid = 1'b1;
        if_rsp_q.push_back(32'h0BAD_CAFE);
        #1; observe();
        check("dr_fetch_valid", 64'(if_rdata_valid), 64'd1);
        @(negedge clk);
        Read_data_Valid = 1'b0; Mem_Req_Ready = 1'b0;
        #1; observe();
        check("dr_done_owner", 64'(arb_owner), 64'd0);

        // Reset asserted while in the fetch response state
        @(negedge clk);
        if_addr = 32'h0000_7000; if_read = 1'b1; Mem_Req_Ready = 1'b1;
        push_req(32'h0000_7000, 1'b0, 32'h0, 4'h0);
        #1; observe();
        @(negedge clk); #1; observe();
        check("mr_req_owner", 64'(arb_owner), 64'd1);
        @(negedge clk);
        if_read = 1'b0; if_rdata_ready = 1'b0; Read_data = 32'h1111_1111; Read_data_Valid = 1'b1;
        #1; observe();
        check("mr_rsp_valid", 64'(if_rdata_valid), 64'd1);
        check("mr_rsp_rdr", 64'(Read_data_Ready), 64'd0);
        #2; rst_n = 1'b0; #1;
        check("mr_rst_owner", 64'(arb_owner), 64'd0);
        check("mr_rst_valid", 64'(if_rdata_valid), 64'd0);
        check("mr_rst_rdr", 64'(Read_data_Ready), 64'd1);
        check("mr_rst_memread", 64'(MemRead), 64'd0);
        check("mr_rst_if_req_ready", 64'(if_req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1; observe();
        check("mr_rel_rdr", 64'(Read_data_Ready), 64'd1);
        check("mr_rel_owner", 64'(arb_owner), 64'd0);
        @(negedge clk);
        Read_data_Valid = 1'b0; if_rdata_ready = 1'b1;
        #1; observe();
        check("mr_flush_done_rdr", 64'(Read_data_Ready), 64'd0);
        fetch_read(32'h0000_8000, 32'h2222_3333);

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("if_rsp_q_empty", 64'(if_rsp_q.size()), 64'd0);
        check("dm_rsp_q_empty", 64'(dm_rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
